ro_freq_meter: RTL

Measures the frequency of the free-running ring oscillator by enabling it, counting its rising edges over a fixed gate window of system clocks, and reporting the edge count. Sits between the ring oscillator macro, whose enable it drives and whose asynchronous output it samples, and the control logic that issues measurement requests. Provides the clocked, synchronous read side of the oscillator.

---
 rtl/ro_meter_pkg.sv | 29 ++
 rtl/sync_edge_det.sv | 42 ++++
 rtl/ro_freq_meter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ro_meter_pkg.sv
// Shared definitions for the ring-oscillator frequency meter: FSM state
// encoding, default parameter values and counter-width helpers.
package ro_meter_pkg;

  // Measurement sequence states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    GATE   = 2'd2,
    DONE   = 2'd3
  } meter_state_t;

  // Default parameter values.
  localparam int DEF_GATE_CYCLES   = 1024;
  localparam int DEF_SETTLE_CYCLES = 8;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_CNT_W         = 16;

  // Width needed to hold a cycle count of 0..cycles.
  function automatic int gate_cnt_w(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

  // Larger of two integers, used to size the shared settle/gate timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level input, followed by a
// one-cycle rising-edge pulse. Usable for any slow async monitor signal.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise
);

  logic [STAGES-1:0] sync_reg;
  logic              sync_q_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        // First stage captures the asynchronous input (may go metastable).
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[0] <= 1'b0;
          else        sync_reg[0] <= raw;
        end
      end else begin : g_chain
        // Later stages give the first stage time to resolve.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= 1'b0;
          else        sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  // Delayed copy of the synchronized level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q_reg <= 1'b0;
    else        sync_q_reg <= sync_reg[STAGES-1];
  end

  assign rise = sync_reg[STAGES-1] & ~sync_q_reg;

endmodule

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: enables the oscillator, lets it settle,
// counts synchronized rising edges over a fixed gate window and reports a
// saturating edge count with an overflow flag.
module ro_freq_meter
  import ro_meter_pkg::*;
#(
  parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ro_in,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  // One down-counter serves both the settle and the gate interval.
  localparam int TMR_W = max_int(gate_cnt_w(GATE_CYCLES), gate_cnt_w(SETTLE_CYCLES));
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  meter_state_t     state_reg, state_next;
  logic [TMR_W-1:0] tmr_reg, tmr_next;
  logic [CNT_W-1:0] work_reg, work_next;
  logic             work_ovf_reg, work_ovf_next;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;
  logic             ro_rise;
  logic             gate_last;

  // Synchronize the oscillator output and turn it into edge pulses.
  sync_edge_det #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (ro_in),
    .rise (ro_rise)
  );

  assign gate_last = (state_reg == GATE) && (tmr_reg == '0);

  // State, timer and working edge counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      tmr_reg      <= '0;
      work_reg     <= '0;
      work_ovf_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tmr_reg      <= tmr_next;
      work_reg     <= work_next;
      work_ovf_reg <= work_ovf_next;
    end
  end

  // Next-state logic, interval timing and saturating edge accumulation.
  always_comb begin
    state_next    = state_reg;
    tmr_next      = tmr_reg;
    work_next     = work_reg;
    work_ovf_next = work_ovf_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = WARMUP;
          tmr_next      = SETTLE_LOAD;
          work_next     = '0;
          work_ovf_next = 1'b0;
        end
      end
      WARMUP: begin
        // Edges here are ignored; the detector history still advances.
        if (tmr_reg == '0) begin
          state_next = GATE;
          tmr_next   = GATE_LOAD;
        end else begin
          tmr_next = tmr_reg - 1'b1;
        end
      end
      GATE: begin
        if (ro_rise) begin
          if (work_reg == CNT_MAX) work_ovf_next = 1'b1;
          else                     work_next     = work_reg + 1'b1;
        end
        if (tmr_reg == '0) state_next = DONE;
        else               tmr_next   = tmr_reg - 1'b1;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Result registers load on the last gate cycle (including that cycle's
  // edge) so they are already valid while done is high, and hold afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (gate_last) begin
      count_reg    <= work_next;
      overflow_reg <= work_ovf_next;
    end
  end

  assign ro_en    = (state_reg == WARMUP) || (state_reg == GATE);
  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);
  assign count    = count_reg;
  assign overflow = overflow_reg;

endmodule
